seq_div_2w_w: RTL

Sequential unsigned restoring divider: a 2·WIDTH-bit dividend divided by a WIDTH-bit divisor gives a 2·WIDTH-bit quotient and a WIDTH-bit remainder. It computes one quotient bit per cycle behind valid/ready handshakes on both sides. It is the inverse-operation companion to the 8x8 Dadda multipliers. Verification benches use it to map approximate products back to operands, and datapaths use it where an exact divide is needed next to an approximate multiply.

---
 rtl/seq_div_2w_w.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seq_div_2w_w.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
// Define DIV_REMAINDER_EN to get the remainder output port and its register.
module seq_div_2w_w #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0]     remainder,
`endif
  output logic                 div_by_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient bits shift in at LSB
  logic [WIDTH:0]    pr_q, pr_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic              dbz_q, dbz_d;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0]  rem_q, rem_d;
`endif

  logic [WIDTH:0]    pr_sh, pr_nxt;
  logic [DW-1:0]     dvd_nxt;
  logic              fits;

  always_comb begin
    pr_sh   = {pr_q[WIDTH-1:0], dvd_q[DW-1]};
    fits    = (pr_sh >= {1'b0, dvs_q});
    pr_nxt  = fits ? (pr_sh - {1'b0, dvs_q}) : pr_sh;
    dvd_nxt = {dvd_q[DW-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
`ifdef DIV_REMAINDER_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          pr_d  = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            // Divide-by-zero resolves immediately with a saturated quotient.
            state_d = DONE;
            quo_d   = '1;
            dbz_d   = 1'b1;
`ifdef DIV_REMAINDER_EN
            rem_d   = dividend[WIDTH-1:0];
`endif
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        pr_d  = pr_nxt;
        dvd_d = dvd_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
          quo_d   = dvd_nxt;
          dbz_d   = 1'b0;
`ifdef DIV_REMAINDER_EN
          rem_d   = pr_nxt[WIDTH-1:0];
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
`ifdef DIV_REMAINDER_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign div_by_zero = dbz_q;
`ifdef DIV_REMAINDER_EN
  assign remainder   = rem_q;
`endif

endmodule
